// File: rtl/arm_dmem_pkg.sv
// Shared encodings and lane helpers for the ARM data memory controller.
// Steering and extension live here so that the top level stays a plain datapath.
package arm_dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: lane_en = 4'b0001 << off;
         SZ_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      misaligned = (size == SZ_ILL) ||
                   ((size == SZ_HALF) && off[0]) ||
                   ((size == SZ_WORD) && (off != 2'b00));
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic sign);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: load_ext = {{24{sign & sh[7]}}, sh[7:0]};
         SZ_HALF: load_ext = {{16{sign & sh[15]}}, sh[15:0]};
         default: load_ext = word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port word RAM built from four byte-lane arrays, registered read, no reset.
// Read-during-write returns the old contents of the addressed word.
module dmem_bram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_mem [DEPTH];
         logic [7:0] r_q;

         always_ff @(posedge clk) begin
            if (i_we[gi])
               r_mem[i_addr] <= i_wdata[gi*8 +: 8];
            r_q <= r_mem[i_addr];
         end

         assign o_rdata[gi*8 +: 8] = r_q;
      end
   endgenerate

endmodule

// File: rtl/arm_dmem_ctrl.sv
// Byte-addressed data memory for the ARM MEM stage: zero-fill sweep, lane steering, sign/zero extension.
// Optional macro DMEM_OUTREG_EN adds one output register stage (load and err latency become 2).
module arm_dmem_ctrl
   import arm_dmem_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              err
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

   state_t            r_state, w_state_next;
   logic [IDX_W-1:0]  r_idx, w_idx_next;
   logic              w_idle, w_accept, w_bad, w_load, w_store;
   logic [3:0]        w_ram_we;
   logic [IDX_W-1:0]  w_ram_idx;
   logic [31:0]       w_ram_wdata, w_ram_q, w_st_data, w_rdata;
   logic [1:0]        r_ld_size, r_ld_off;
   logic              r_ld_sign, r_rvalid, r_err;
   logic [31:0]       r_rdata;

   assign w_idle   = (r_state == ST_IDLE);
   assign ready    = w_idle;
   assign w_accept = req & w_idle;
   assign w_bad    = misaligned(size, addr[1:0]);
   assign w_load   = w_accept & ~we & ~w_bad;
   assign w_store  = w_accept & we & ~w_bad;

   // Replicate the low store bits across all lanes; the lane enables pick the target.
   always_comb begin
      case (size)
         SZ_BYTE: w_st_data = {4{wdata[7:0]}};
         SZ_HALF: w_st_data = {2{wdata[15:0]}};
         default: w_st_data = wdata;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_ram_we     = 4'b0000;
      w_ram_idx    = addr[ADDR_W-1:2];
      w_ram_wdata  = w_st_data;
      case (r_state)
         ST_INIT: begin
            w_ram_we    = 4'b1111;
            w_ram_idx   = r_idx;
            w_ram_wdata = 32'h0;
            if (r_idx == IDX_LAST)
               w_state_next = ST_IDLE;
            else
               w_idx_next = r_idx + 1'b1;
         end
         default: begin
            if (w_store)
               w_ram_we = lane_en(size, addr[1:0]);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT_ZERO ? ST_INIT : ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
      end
   end

   dmem_bram #(.DEPTH(DEPTH), .AW(IDX_W)) u_bram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_idx),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_q)
   );

   // The RAM output register is the load pipeline stage; r_rdata only holds the last result.
   assign w_rdata = r_rvalid ? load_ext(w_ram_q, r_ld_size, r_ld_off, r_ld_sign) : r_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= 32'h0;
         r_ld_size <= SZ_WORD;
         r_ld_off  <= 2'b00;
         r_ld_sign <= 1'b0;
      end else begin
         r_rvalid <= w_load;
         r_err    <= w_accept & w_bad;
         r_rdata  <= w_rdata;
         if (w_load) begin
            r_ld_size <= size;
            r_ld_off  <= addr[1:0];
            r_ld_sign <= sign;
         end
      end
   end

`ifdef DMEM_OUTREG_EN
   logic        r_rvalid_o, r_err_o;
   logic [31:0] r_rdata_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid_o <= 1'b0;
         r_err_o    <= 1'b0;
         r_rdata_o  <= 32'h0;
      end else begin
         r_rvalid_o <= r_rvalid;
         r_err_o    <= r_err;
         r_rdata_o  <= w_rdata;
      end
   end

   assign rvalid = r_rvalid_o;
   assign err    = r_err_o;
   assign rdata  = r_rdata_o;
`else
   assign rvalid = r_rvalid;
   assign err    = r_err;
   assign rdata  = w_rdata;
`endif

endmodule

// File: tb/tb_arm_dmem_ctrl.sv
// Scoreboard bench for arm_dmem_ctrl: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_arm_dmem_ctrl;

`ifdef DMEM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [1:0] SZB = 2'b00, SZH = 2'b01, SZW = 2'b10, SZI = 2'b11;

   logic        clk = 1'b0;
   logic        rst, req, we, sign;
   logic [1:0]  size;
   logic [7:0]  addr;
   logic [31:0] wdata, rdata;
   logic        ready, rvalid, err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] last_rdata = 32'h0;

   typedef struct {
      logic        is_err;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   arm_dmem_ctrl #(.ADDR_W(8), .INIT_ZERO(1'b1)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .we     (we),
      .size   (size),
      .sign   (sign),
      .addr   (addr),
      .wdata  (wdata),
      .ready  (ready),
      .rdata  (rdata),
      .rvalid (rvalid),
      .err    (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rvalid && err) begin
         checks++;
         errors++;
         $display("FAIL rvalid_err_overlap rvalid=%b err=%b required not both high", rvalid, err);
      end
      if (rvalid || err) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d rvalid=%b err=%b rdata=%h required no output",
                     cyc, rvalid, err, rdata);
         end else begin
            mon_e = sbq.pop_front();
            if (rvalid !== !mon_e.is_err || err !== mon_e.is_err || rdata !== mon_e.data || cyc != mon_e.cyc) begin
               errors++;
               $display("FAIL response cyc=%0d rvalid=%b err=%b rdata=%h required cyc=%0d err=%b rdata=%h",
                        cyc, rvalid, err, rdata, mon_e.cyc, mon_e.is_err, mon_e.data);
            end else
               $display("ok   cyc=%0d %s rdata=%h", cyc, mon_e.is_err ? "err  " : "load ", rdata);
         end
      end else if (sbq.size() > 0 && cyc >= sbq[0].cyc) begin
         checks++;
         errors++;
         mon_e = sbq.pop_front();
         $display("FAIL missing_output cyc=%0d rvalid=%b err=%b required err=%b rdata=%h",
                  cyc, rvalid, err, mon_e.is_err, mon_e.data);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end else
         $display("ok   %s = %h", name, act);
   endtask

   task automatic access(input logic w, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_data);
      int t;
      exp_t e;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
      t = 0;
      while (!ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout addr=%h ready=%b required 1", a, ready);
      end else begin
         $display("req  cyc=%0d we=%b size=%b sign=%b addr=%h wdata=%h", cyc, w, sz, sg, a, wd);
         if (exp_err) begin
            e.is_err = 1'b1; e.data = last_rdata; e.cyc = cyc + LAT;
            sbq.push_back(e);
         end else if (!w) begin
            e.is_err = 1'b0; e.data = exp_data; e.cyc = cyc + LAT;
            sbq.push_back(e);
            last_rdata = exp_data;
         end
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      req = 1'b0;
   endtask

   // Counts negedges with ready low, starting at the negedge where rst was released.
   task automatic count_init(input string name);
      int n;
      n = 0;
      while (!ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'd64);
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_rdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; size = SZW; sign = 1'b0; addr = 8'h0; wdata = 32'h0;
      repeat (2) @(negedge clk);
      check("reset_ready", {31'h0, ready}, 32'h0);
      check("reset_rvalid", {31'h0, rvalid}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      rst = 1'b0;
      count_init("sweep_len");

      // Every word reads back zero after the sweep, back-to-back at full rate.
      for (int i = 0; i < 64; i++)
         access(1'b0, SZW, 1'b0, 8'(i * 4), 32'h0, 1'b0, 32'h0);
      idle();

      access(1'b1, SZW, 1'b0, 8'h04, 32'hA0A0A0A0, 1'b0, 32'h0);
      access(1'b1, SZB, 1'b0, 8'h05, 32'hFFFFFF5F, 1'b0, 32'h0);
      access(1'b0, SZW, 1'b0, 8'h04, 32'h0, 1'b0, 32'hA0A05FA0);

      access(1'b1, SZH, 1'b0, 8'h0A, 32'h12348001, 1'b0, 32'h0);
      access(1'b0, SZH, 1'b1, 8'h0A, 32'h0, 1'b0, 32'hFFFF8001);
      access(1'b0, SZH, 1'b0, 8'h0A, 32'h0, 1'b0, 32'h00008001);
      access(1'b0, SZB, 1'b1, 8'h0B, 32'h0, 1'b0, 32'hFFFFFF80);
      access(1'b0, SZB, 1'b0, 8'h0A, 32'h0, 1'b0, 32'h00000001);
      access(1'b0, SZH, 1'b1, 8'h05, 32'h0, 1'b1, 32'h0);
      access(1'b0, SZB, 1'b1, 8'h05, 32'h0, 1'b0, 32'h0000005F);
      idle();

      access(1'b0, SZW, 1'b0, 8'h06, 32'h0, 1'b1, 32'h0);
      access(1'b1, SZH, 1'b0, 8'h03, 32'h0000BEEF, 1'b1, 32'h0);
      access(1'b1, SZI, 1'b0, 8'h04, 32'hDEADBEEF, 1'b1, 32'h0);
      access(1'b0, SZW, 1'b0, 8'h04, 32'h0, 1'b0, 32'hA0A05FA0);
      idle();

      access(1'b1, SZW, 1'b0, 8'h00, 32'h11223344, 1'b0, 32'h0);
      access(1'b0, SZW, 1'b0, 8'h00, 32'h0, 1'b0, 32'h11223344);
      access(1'b0, SZW, 1'b0, 8'h04, 32'h0, 1'b0, 32'hA0A05FA0);
      access(1'b0, SZW, 1'b0, 8'h08, 32'h0, 1'b0, 32'h80010000);
      idle();
      repeat (4) @(negedge clk);

      // Reset mid-sweep restarts the sweep from word 0.
      rst_pulse();
      repeat (29) @(negedge clk);
      check("mid_sweep_ready", {31'h0, ready}, 32'h0);
      rst_pulse();
      count_init("sweep_restart_len");

      access(1'b1, SZW, 1'b0, 8'h10, 32'hCAFEF00D, 1'b0, 32'h0);
      idle();
      // A load accepted in the reset cycle must never produce rvalid.
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = SZW; addr = 8'h10; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      last_rdata = 32'h0;
      check("pending_drop_rdata", rdata, 32'h0);
      count_init("sweep_after_pending");
      access(1'b0, SZW, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0);
      access(1'b0, SZW, 1'b0, 8'h04, 32'h0, 1'b0, 32'h0);
      idle();

      repeat (6) @(negedge clk);
      check("scoreboard_empty", 32'(sbq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
